// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 receive path.
package ps2_pkg;

   localparam int FRAME_DATA_BITS = 8;

   typedef enum logic [1:0] {
      IDLE,
      DATA,
      PARITY,
      STOP
   } rx_state_e;

   // True when the data byte plus its parity bit carry an odd number of ones.
   function automatic logic odd_ones(input logic [FRAME_DATA_BITS-1:0] d, input logic p);
      return ^{d, p};
   endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// Two-flop synchroniser followed by a run-length filter: the output only
// follows the synced line after FILTER_LEN consecutive differing samples.
module ps2_line_filter #(
   parameter int FILTER_LEN = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic raw,
   output logic filt
);

   localparam int CW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

   logic          meta;
   logic          sync;
   logic [CW-1:0] run_cnt;

   // NOTE: every register here uses <= so all flops sample the old values of
   // their neighbours at the same edge; a blocking = would collapse the chain.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         meta    <= 1'b1;
         sync    <= 1'b1;
         filt    <= 1'b1;
         run_cnt <= '0;
      end else begin
         meta <= raw;
         sync <= meta;
         if (sync != filt) begin
            if (run_cnt == CW'(FILTER_LEN - 1)) begin
               filt    <= sync;
               run_cnt <= '0;
            end else begin
               run_cnt <= run_cnt + 1'b1;
            end
         end else begin
            run_cnt <= '0;
         end
      end
   end

endmodule

// File: rtl/ps2_rx_fifo.sv
// PS/2 device-to-host receiver: conditions the pins, deframes 11-bit frames,
// queues good bytes in a show-ahead FIFO and reports sticky error flags.
module ps2_rx_fifo
   import ps2_pkg::*;
#(
   parameter int FILTER_LEN  = 4,
   parameter int DEPTH       = 8,
   parameter int TIMEOUT_CYC = 2000
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       ps2_clk,
   input  logic                       ps2_data,
   input  logic                       rd_en,
   output logic [7:0]                 rd_data,
   output logic                       rd_valid,
   output logic [$clog2(DEPTH+1)-1:0] fifo_count,
   input  logic                       err_clr,
   output logic                       err_parity,
   output logic                       err_frame,
   output logic                       err_overflow
);

   localparam int PW  = $clog2(DEPTH);
   localparam int CNW = $clog2(DEPTH + 1);
   localparam int TCW = $clog2(TIMEOUT_CYC + 1);

   logic filt_clk, filt_data, clk_prev, fall;

   ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filter (
      .clk  (clk),
      .rst_n(rst_n),
      .raw  (ps2_clk),
      .filt (filt_clk)
   );

   ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_data_filter (
      .clk  (clk),
      .rst_n(rst_n),
      .raw  (ps2_data),
      .filt (filt_data)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) clk_prev <= 1'b1;
      else        clk_prev <= filt_clk;
   end

   assign fall = clk_prev & ~filt_clk;

   // ---------------- Deframer ----------------
   rx_state_e                  state;
   logic [2:0]                 bit_cnt;
   logic [FRAME_DATA_BITS-1:0] shift;
   logic                       par_bit;
   logic [TCW-1:0]             tcnt;

   logic timeout, stop_eval, push, parity_err, frame_err;

   assign timeout    = (state != IDLE) && !fall && (tcnt == TCW'(TIMEOUT_CYC - 1));
   assign stop_eval  = (state == STOP) && fall;
   assign push       = stop_eval && filt_data && odd_ones(shift, par_bit);
   assign parity_err = stop_eval && filt_data && !odd_ones(shift, par_bit);
   assign frame_err  = (stop_eval && !filt_data) || timeout;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state   <= IDLE;
         bit_cnt <= '0;
         shift   <= '0;
         par_bit <= 1'b0;
         tcnt    <= '0;
      end else begin
         if (state == IDLE || fall) tcnt <= '0;
         else                       tcnt <= tcnt + 1'b1;

         if (timeout) begin
            state <= IDLE;
         end else if (fall) begin
            case (state)
               IDLE: begin
                  // A high start bit is line noise, not a frame.
                  if (!filt_data) begin
                     state   <= DATA;
                     bit_cnt <= '0;
                  end
               end
               DATA: begin
                  shift <= {filt_data, shift[FRAME_DATA_BITS-1:1]};
                  if (bit_cnt == 3'(FRAME_DATA_BITS - 1)) state <= PARITY;
                  else                                    bit_cnt <= bit_cnt + 1'b1;
               end
               PARITY: begin
                  par_bit <= filt_data;
                  state   <= STOP;
               end
               STOP:    state <= IDLE;
               default: state <= IDLE;
            endcase
         end
      end
   end

   // ---------------- FIFO ----------------
   logic [7:0]     mem [DEPTH];
   logic [PW-1:0]  wr_ptr, rd_ptr;
   logic [CNW-1:0] count;
   logic           full, pop, do_push, overflow_set;

   assign full         = (count == CNW'(DEPTH));
   assign pop          = rd_en && (count != '0);
   assign do_push      = push && (!full || pop);
   assign overflow_set = push && full && !pop;

   // NOTE: the storage array has no reset; its contents are only observable
   // through rd_data when count says an entry is valid.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= shift;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)     rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   assign rd_valid   = (count != '0);
   assign rd_data    = rd_valid ? mem[rd_ptr] : 8'h00;
   assign fifo_count = count;

   // ---------------- Sticky errors: set beats clear ----------------
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         err_parity   <= 1'b0;
         err_frame    <= 1'b0;
         err_overflow <= 1'b0;
      end else begin
         if (parity_err)   err_parity <= 1'b1;
         else if (err_clr) err_parity <= 1'b0;
         if (frame_err)    err_frame <= 1'b1;
         else if (err_clr) err_frame <= 1'b0;
         if (overflow_set) err_overflow <= 1'b1;
         else if (err_clr) err_overflow <= 1'b0;
      end
   end

endmodule

// File: tb/tb_ps2_rx_fifo.sv
// Directed bench for ps2_rx_fifo: drives bit-level PS/2 frames and checks
// the FIFO read port and sticky flags against hand-computed values.
module tb_ps2_rx_fifo;

   localparam int FILTER_LEN  = 4;
   localparam int DEPTH       = 8;
   localparam int TIMEOUT_CYC = 2000;
   localparam int HALF        = 20;

   logic       clk = 1'b0;
   logic       rst_n, ps2_clk, ps2_data, rd_en, err_clr;
   logic [7:0] rd_data;
   logic       rd_valid, err_parity, err_frame, err_overflow;
   logic [$clog2(DEPTH+1)-1:0] fifo_count;

   int n_vec = 0;
   int n_err = 0;

   ps2_rx_fifo #(
      .FILTER_LEN (FILTER_LEN),
      .DEPTH      (DEPTH),
      .TIMEOUT_CYC(TIMEOUT_CYC)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .ps2_clk     (ps2_clk),
      .ps2_data    (ps2_data),
      .rd_en       (rd_en),
      .rd_data     (rd_data),
      .rd_valid    (rd_valid),
      .fifo_count  (fifo_count),
      .err_clr     (err_clr),
      .err_parity  (err_parity),
      .err_frame   (err_frame),
      .err_overflow(err_overflow)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic wait_cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Optionally pulses rd_en in the cycle the DUT sees this bit's falling edge
   // (2-flop synchroniser plus FILTER_LEN filter samples after the pin drops).
   task automatic ps2_bit(input logic b, input logic pop_on_fall);
      ps2_data = b;
      wait_cyc(HALF / 2);
      ps2_clk = 1'b0;
      if (pop_on_fall) begin
         wait_cyc(2 + FILTER_LEN);
         rd_en = 1'b1;
         wait_cyc(1);
         rd_en = 1'b0;
         wait_cyc(HALF - 3 - FILTER_LEN);
      end else begin
         wait_cyc(HALF);
      end
      ps2_clk = 1'b1;
      wait_cyc(HALF / 2);
   endtask

   task automatic send_frame(input logic [7:0] d, input logic par, input logic stp,
                             input logic pop_last);
      ps2_bit(1'b0, 1'b0);
      for (int i = 0; i < 8; i++) ps2_bit(d[i], 1'b0);
      ps2_bit(par, 1'b0);
      ps2_bit(stp, pop_last);
      ps2_data = 1'b1;
      wait_cyc(10);
   endtask

   function automatic logic good_par(input logic [7:0] d);
      return ~^d;
   endfunction

   task automatic send_good(input logic [7:0] d);
      send_frame(d, good_par(d), 1'b1, 1'b0);
   endtask

   task automatic pop_one;
      rd_en = 1'b1;
      wait_cyc(1);
      rd_en = 1'b0;
   endtask

   task automatic clear_errs;
      err_clr = 1'b1;
      wait_cyc(1);
      err_clr = 1'b0;
      wait_cyc(1);
   endtask

   initial begin
      rst_n = 1'b0; ps2_clk = 1'b1; ps2_data = 1'b1; rd_en = 1'b0; err_clr = 1'b0;
      wait_cyc(5);
      rst_n = 1'b1;
      wait_cyc(2);
      check("rst_valid", 16'(rd_valid), 16'h0);
      check("rst_data", 16'(rd_data), 16'h00);
      check("rst_count", 16'(fifo_count), 16'h0);
      check("rst_flags", 16'({err_parity, err_frame, err_overflow}), 16'h0);

      // Good frame 0x1C (three ones, parity bit 0)
      send_frame(8'h1C, 1'b0, 1'b1, 1'b0);
      check("good_valid", 16'(rd_valid), 16'h1);
      check("good_data", 16'(rd_data), 16'h1C);
      check("good_count", 16'(fifo_count), 16'h1);
      check("good_flags", 16'({err_parity, err_frame, err_overflow}), 16'h0);
      pop_one();
      check("pop_empty", 16'(rd_valid), 16'h0);
      check("pop_data0", 16'(rd_data), 16'h00);

      // 0x5A has four ones; parity bit 0 leaves the total even
      send_frame(8'h5A, 1'b0, 1'b1, 1'b0);
      check("par_err", 16'(err_parity), 16'h1);
      check("par_nopush", 16'(fifo_count), 16'h0);
      clear_errs();
      check("par_clr", 16'(err_parity), 16'h0);

      // Good parity but low stop bit
      send_frame(8'h5A, 1'b1, 1'b0, 1'b0);
      check("stop_err", 16'(err_frame), 16'h1);
      check("stop_nopar", 16'(err_parity), 16'h0);
      check("stop_nopush", 16'(fifo_count), 16'h0);
      clear_errs();
      check("stop_clr", 16'(err_frame), 16'h0);

      // One-cycle clock glitch with data low must not start a frame
      ps2_data = 1'b0;
      wait_cyc(2);
      ps2_clk = 1'b0;
      wait_cyc(1);
      ps2_clk = 1'b1;
      wait_cyc(2);
      ps2_data = 1'b1;
      wait_cyc(20);
      send_good(8'h3C);
      check("glitch_count", 16'(fifo_count), 16'h1);
      check("glitch_data", 16'(rd_data), 16'h3C);
      check("glitch_flags", 16'({err_parity, err_frame, err_overflow}), 16'h0);
      pop_one();

      // Abandoned frame: start + 4 data bits, then silence
      ps2_bit(1'b0, 1'b0);
      for (int i = 0; i < 4; i++) ps2_bit(1'b1, 1'b0);
      wait_cyc(TIMEOUT_CYC + 100);
      check("to_err", 16'(err_frame), 16'h1);
      check("to_nopush", 16'(fifo_count), 16'h0);
      clear_errs();
      send_good(8'h1C);
      check("to_next_count", 16'(fifo_count), 16'h1);
      check("to_next_data", 16'(rd_data), 16'h1C);
      check("to_next_flags", 16'({err_parity, err_frame, err_overflow}), 16'h0);
      pop_one();
      wait_cyc(1);

      // DEPTH+1 frames with no reads: last byte dropped
      for (int i = 0; i <= DEPTH; i++) send_good(8'hA0 + 8'(i));
      check("ovf_count", 16'(fifo_count), 16'(DEPTH));
      check("ovf_flag", 16'(err_overflow), 16'h1);
      for (int i = 0; i < DEPTH; i++) begin
         check($sformatf("ovf_rd%0d", i), 16'(rd_data), 16'(8'hA0 + 8'(i)));
         pop_one();
      end
      check("ovf_drained", 16'(rd_valid), 16'h0);
      clear_errs();
      check("ovf_clr", 16'(err_overflow), 16'h0);

      // Same again but pop exactly as the last byte is pushed
      for (int i = 0; i < DEPTH; i++) send_good(8'hB0 + 8'(i));
      send_frame(8'hB8, good_par(8'hB8), 1'b1, 1'b1);
      check("pp_count", 16'(fifo_count), 16'(DEPTH));
      check("pp_noovf", 16'(err_overflow), 16'h0);
      for (int i = 1; i <= DEPTH; i++) begin
         check($sformatf("pp_rd%0d", i), 16'(rd_data), 16'(8'hB0 + 8'(i)));
         pop_one();
      end
      check("pp_drained", 16'(fifo_count), 16'h0);

      // Reset mid-frame with bytes queued and a flag set
      send_frame(8'h5A, 1'b0, 1'b1, 1'b0);
      send_good(8'h11);
      send_good(8'h22);
      send_good(8'h33);
      check("mr_pre_count", 16'(fifo_count), 16'h3);
      check("mr_pre_par", 16'(err_parity), 16'h1);
      ps2_bit(1'b0, 1'b0);
      for (int i = 0; i < 3; i++) ps2_bit(1'b1, 1'b0);
      rst_n = 1'b0;
      wait_cyc(1);
      rst_n = 1'b1;
      wait_cyc(1);
      check("mr_valid", 16'(rd_valid), 16'h0);
      check("mr_count", 16'(fifo_count), 16'h0);
      check("mr_flags", 16'({err_parity, err_frame, err_overflow}), 16'h0);
      wait_cyc(20);
      send_good(8'h1C);
      check("mr_next_data", 16'(rd_data), 16'h1C);
      check("mr_next_count", 16'(fifo_count), 16'h1);
      check("mr_next_flags", 16'({err_parity, err_frame, err_overflow}), 16'h0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
